// File: rtl/ctl_seq_pkg.sv
// Shared types and the control-word pattern generator for the sequencer.
package ctl_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  typedef enum logic [1:0] {RING, JOHNSON, BINARY, GRAY} mode_t;

  localparam int PAT_MAXW = 32;

  // Returns pattern k for a word of 'width' bits (width <= PAT_MAXW); upper bits are zero.
  function automatic logic [PAT_MAXW-1:0] pat_gen(mode_t mode, int unsigned k, int unsigned width);
    logic [63:0]  mask;
    logic [63:0]  r;
    int unsigned  j;
    mask = (64'd1 << width) - 64'd1;
    r    = '0;
    j    = 0;
    case (mode)
      RING:    r = 64'd1 << (k % width);
      JOHNSON: begin
        j = k % (2 * width);
        if (j < width) r = (64'd1 << (j + 1)) - 64'd1;
        else           r = ~((64'd1 << (j - width + 1)) - 64'd1);
      end
      BINARY:  r = {32'd0, k};
      GRAY:    r = {32'd0, k ^ (k >> 1)};
      default: r = '0;
    endcase
    r = r & mask;
    return r[PAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/ctl_dwell_timer.sv
// Dwell counter: counts while enabled, pulses tc_o on the cycle it reaches the limit.
module ctl_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] limit_i,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (tc_o)    cnt_d = '0;
    else if (en_i)    cnt_d = cnt_q + DWELL_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ctl_seq_gen.sv
// Control-word sequencer: steps through NUM_STEPS patterns with a per-step dwell,
// start/busy/done handshake, loop, pause and abort.
module ctl_seq_gen
  import ctl_seq_pkg::*;
#(
  parameter  int W_WIDTH   = 6,
  parameter  int NUM_STEPS = 6,
  parameter  int DWELL_W   = 4,
  localparam int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [W_WIDTH-1:0] w,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [W_WIDTH-1:0]   w_q, w_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_pat;
  logic                 step_end;

  // Counter only advances in RUN; it is held cleared whenever no sequence is active.
  ctl_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   ((state_q == IDLE) || (state_q == DONE)),
    .en_i    (state_q == RUN),
    .limit_i (dwell_q),
    .tc_o    (step_end)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    step_d   = step_q;
    w_d      = w_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_pat = 1'b0;
    case (state_q)
      IDLE: begin
        w_d    = '0;
        busy_d = 1'b0;
        step_d = '0;
        if (start) begin
          mode_d   = mode_t'(mode);
          dwell_d  = dwell;
          state_d  = RUN;
          busy_d   = 1'b1;
          load_pat = 1'b1;
        end
      end
      RUN: begin
        if (step_end) begin
          if (step_q != LAST) begin
            step_d   = step_q + STEP_W'(1);
            load_pat = 1'b1;
          end else if (loop_en) begin
            step_d   = '0;
            load_pat = 1'b1;
          end else begin
            state_d = DONE;
            step_d  = '0;
            w_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        // A step that ends while pausing still advances; the new step is then held.
        if (pause && (state_d == RUN)) state_d = HOLD;
      end
      HOLD: begin
        if (!pause) state_d = RUN;
      end
      DONE: begin
        state_d = IDLE;
        w_d     = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (load_pat) w_d = W_WIDTH'(pat_gen(mode_d, 32'(step_d), W_WIDTH));

    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
      w_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= RING;
      dwell_q <= '0;
      step_q  <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w    = w_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ctl_seq_gen.sv
// Scoreboard bench for ctl_seq_gen: expected outputs are queued as stimulus is driven.
module tb_ctl_seq_gen;

  localparam int W  = 6;
  localparam int N  = 6;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort, pause, loop_en;
  logic [1:0]    mode;
  logic [DW-1:0] dwell;
  logic [W-1:0]  w;
  logic [2:0]    step;
  logic          busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  string cur_test = "reset";

  typedef struct packed {
    logic [W-1:0] w;
    logic [2:0]   step;
    logic         use_step;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];

  // Expected patterns per mode (RING, JOHNSON, BINARY, GRAY) for W=6, steps 0..5.
  logic [W-1:0] pat_tab [4][N] = '{
    '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20},
    '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F},
    '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05},
    '{6'h00, 6'h01, 6'h03, 6'h02, 6'h06, 6'h07}
  };

  ctl_seq_gen #(.W_WIDTH(W), .NUM_STEPS(N), .DWELL_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pause   (pause),
    .loop_en (loop_en),
    .mode    (mode),
    .dwell   (dwell),
    .w       (w),
    .step    (step),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h at %0t", cur_test, tag, obs, exp, $time);
    end
  endtask

  // Queue one cycle of expected outputs, advance past the edge and compare.
  task automatic expect_cycle(input logic [W-1:0] ew, input int es, input logic use_s,
                              input logic eb, input logic ed);
    exp_t e;
    e.w = ew; e.step = 3'(es); e.use_step = use_s; e.busy = eb; e.done = ed;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("w", 32'(w), 32'(e.w));
    check_val("busy", 32'(busy), 32'(e.busy));
    check_val("done", 32'(done), 32'(e.done));
    if (e.use_step) check_val("step", 32'(step), 32'(e.step));
    @(negedge clk);
  endtask

  task automatic run_steps(input int m, input int dw, input int k0, input int k1);
    for (int k = k0; k <= k1; k++)
      for (int d = 0; d <= dw; d++)
        expect_cycle(pat_tab[m][k], k, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic begin_seq(input int m, input int dw, input logic le);
    start = 1'b1; mode = 2'(m); dwell = DW'(dw); loop_en = le;
    expect_cycle(pat_tab[m][0], 0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    for (int d = 1; d <= dw; d++)
      expect_cycle(pat_tab[m][0], 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic finish_seq();
    expect_cycle('0, 0, 1'b0, 1'b0, 1'b1);
    expect_cycle('0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) expect_cycle('0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; loop_en = 1'b0;
    mode = 2'd0; dwell = '0;
    repeat (2) @(negedge clk);
    check_val("w", 32'(w), 32'h0);
    check_val("step", 32'(step), 32'h0);
    check_val("busy", 32'(busy), 32'h0);
    check_val("done", 32'(done), 32'h0);
    reset = 1'b0;
    idle_cycles(1);

    cur_test = "ring";
    begin_seq(0, 0, 1'b0);
    run_steps(0, 0, 1, 5);
    finish_seq();

    cur_test = "johnson";
    begin_seq(1, 2, 1'b0);
    run_steps(1, 2, 1, 5);
    finish_seq();

    cur_test = "gray_loop";
    begin_seq(3, 0, 1'b1);
    run_steps(3, 0, 1, 5);
    run_steps(3, 0, 0, 5);
    run_steps(3, 0, 0, 3);
    loop_en = 1'b0;
    run_steps(3, 0, 4, 5);
    finish_seq();

    cur_test = "binary_pause";
    begin_seq(2, 3, 1'b0);
    run_steps(2, 3, 1, 1);
    expect_cycle(pat_tab[2][2], 2, 1'b1, 1'b1, 1'b0);
    expect_cycle(pat_tab[2][2], 2, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) expect_cycle(pat_tab[2][2], 2, 1'b1, 1'b1, 1'b0);
    pause = 1'b0;
    expect_cycle(pat_tab[2][2], 2, 1'b1, 1'b1, 1'b0);
    expect_cycle(pat_tab[2][2], 2, 1'b1, 1'b1, 1'b0);
    run_steps(2, 3, 3, 5);
    finish_seq();

    cur_test = "abort";
    begin_seq(0, 1, 1'b0);
    run_steps(0, 1, 1, 3);
    expect_cycle(pat_tab[0][4], 4, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    expect_cycle('0, 0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    idle_cycles(3);

    cur_test = "start_abort";
    start = 1'b1; abort = 1'b1; mode = 2'd0; dwell = '0;
    expect_cycle('0, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0;
    idle_cycles(2);

    cur_test = "start_busy";
    begin_seq(2, 0, 1'b0);
    run_steps(2, 0, 1, 1);
    start = 1'b1; mode = 2'd0; dwell = 4'd5;
    run_steps(2, 0, 2, 3);
    start = 1'b0;
    run_steps(2, 0, 4, 5);
    finish_seq();

    cur_test = "async_reset";
    begin_seq(0, 2, 1'b0);
    run_steps(0, 2, 1, 2);
    #2;
    reset = 1'b1;
    #1;
    check_val("w", 32'(w), 32'h0);
    check_val("busy", 32'(busy), 32'h0);
    check_val("step", 32'(step), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(1);
    cur_test = "after_reset";
    begin_seq(3, 1, 1'b0);
    run_steps(3, 1, 1, 5);
    finish_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
